regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file for the datapath. It replaces the fixed 32×64, 2-read/1-write register file with configurable data width, register count, read-port count, a second write port, optional write-to-read bypass and a per-register written-since-reset scoreboard. It sits between decode (read addresses) and writeback (write ports). The downstream pipeline reads operands combinationally and uses the scoreboard to detect never-written registers.

## Interface
Parameters:
- DATA_W, 64, width of each register
- NUM_REGS, 32, number of architectural registers; power of two, ≥ 2
- ADDR_W, $clog2(NUM_REGS), address width (derived, not overridden)
- NUM_RD, 2, number of read ports, 1..4
- ZERO_REG, NUM_REGS-1, index hardwired to zero; -1 disables the zero register
- BYPASS, 1, 1 = a read of a register written this cycle returns the incoming write data

Ports:
- clk  in  1  clock; all writes occur on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- rd_addr  in  [NUM_RD][ADDR_W]  read addresses
- rd_data  out  [NUM_RD][DATA_W]  read data, combinational
- we0  in  1  write enable, port 0
- wa0  in  ADDR_W  write address, port 0
- wd0  in  DATA_W  write data, port 0
- we1  in  1  write enable, port 1; has priority over port 0
- wa1  in  ADDR_W  write address, port 1
- wd1  in  DATA_W  write data, port 1
- written  out  NUM_REGS  bit i = 1 if register i has been written since reset
- wr_conflict  out  1  registered flag: the previous cycle had we0 & we1 & (wa0 == wa1)

## Operation
- Storage is NUM_REGS × DATA_W flops.
- On reset_n low, all registers, `written` and `wr_conflict` clear to 0 immediately. This does not wait for clk.
- Write ports: on posedge clk, if weN is set and waN ≠ ZERO_REG, reg[waN] ← wdN and written[waN] ← 1.
- Same-address double write: if we0 and we1 target the same address, port 1 data is stored and port 0 is dropped. wr_conflict is 1 for the following cycle.
- Different-address double write: both writes commit in the same cycle.
- Zero register: writes to ZERO_REG are discarded. written[ZERO_REG] stays 0. Reads of ZERO_REG return 0 regardless of BYPASS.
- Reads: rd_data[k] = reg[rd_addr[k]], combinational.
- Bypass (BYPASS = 1), for a read address ≠ ZERO_REG:
  - if we1 and wa1 == rd_addr[k], return wd1;
  - else if we0 and wa0 == rd_addr[k], return wd0;
  - else return stored data.
- With BYPASS = 0, a read returns the pre-edge stored value until the write edge.
- Reset mid-operation: asserting reset_n low while we0/we1 are high prevents the pending write from committing. The first write after release lands on the first posedge with reset_n high.
- Out-of-range addresses cannot occur, because NUM_REGS is a power of two.

## Timing
- Write latency: 1 edge. Data presented before posedge N is readable (non-bypass) in the cycle after edge N.
- Bypass path: combinational from wd/wa/we to rd_data, zero cycles.
- wr_conflict: asserted for exactly one cycle after the conflicting edge; not sticky.
- written: updated on the same edge as the data write.
- Reset values: rd_data = 0 for all addresses, written = 0, wr_conflict = 0.

## Structure
- Package regfile_pkg holds:
  - the default constants DATA_W_DEF, NUM_REGS_DEF, ZERO_REG_DEF;
  - the function is_zero_reg(addr, zero_idx), which returns 0 when zero_idx = -1.
- Sub-module regfile_rdport: one instance per read port (generate loop). It contains the read mux, the bypass priority logic and the zero-register forcing.
- Storage, write decode, scoreboard and conflict flag live in regfile_mp.

## Test plan
- Reset: drive reset_n low mid-cycle with we0 = 1, wa0 = 3, wd0 = 0xFF. Required: the write is not committed; all rd_data = 0, written = 0, wr_conflict = 0.
- Zero register: we0 = 1, wa0 = 31, wd0 = 0xA0, then read rd_addr[0] = 31. Required: rd_data = 0 and written[31] = 0, including during the write cycle with BYPASS = 1.
- Pattern fill and check:
  - Stimulus: write i × 0x0000010204080001 to registers 0..30 through alternating ports. Then read each register on all NUM_RD ports.
  - Required: every value matches, and written = 0x7FFFFFFF.
- Same-address conflict: we0 = we1 = 1, wa0 = wa1 = 5, wd0 = 0x11, wd1 = 0x22. Required: reg5 = 0x22 and wr_conflict = 1 for one cycle only.
- Dual write: wa0 = 7 / wd0 = 0x77 and wa1 = 8 / wd1 = 0x88 in the same cycle. Required: both registers are updated and wr_conflict = 0.
- Bypass:
  - Stimulus: BYPASS = 1, rd_addr[1] = 9, we0 = 1, wa0 = 9, wd0 = 0x99 while reg9 = 0x5.
  - Required: rd_data[1] = 0x99 before the edge. Rerun with BYPASS = 0: rd_data[1] = 0x5 before the edge and 0x99 after it.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-port register file.
// Imported by the storage top and the read-port slices.
package regfile_pkg;

   localparam int DATA_W_DEF   = 64;
   localparam int NUM_REGS_DEF = 32;
   localparam int ZERO_REG_DEF = NUM_REGS_DEF - 1;

   // A negative zeroIdx means "no hardwired zero register".
   function automatic logic is_zero_reg(input logic [31:0] addr, input int zeroIdx);
      return (zeroIdx >= 0) && (addr == 32'(zeroIdx));
   endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: storage mux, optional write bypass
// (port 1 over port 0) and zero-register forcing.
module regfile_rdport
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int ADDR_W   = $clog2(NUM_REGS),
   parameter int ZERO_REG = NUM_REGS - 1,
   parameter int BYPASS   = 1
) (
   input  logic [ADDR_W-1:0]               rdAddr,
   input  logic [NUM_REGS-1:0][DATA_W-1:0] regs,
   input  logic                            we0,
   input  logic [ADDR_W-1:0]               wa0,
   input  logic [DATA_W-1:0]               wd0,
   input  logic                            we1,
   input  logic [ADDR_W-1:0]               wa1,
   input  logic [DATA_W-1:0]               wd1,
   output logic [DATA_W-1:0]               rdData
);

   always_comb begin
      rdData = regs[rdAddr];
      if (BYPASS != 0) begin
         if (we1 && (wa1 == rdAddr)) begin
            rdData = wd1;
         end else if (we0 && (wa0 == rdAddr)) begin
            rdData = wd0;
         end
      end
      // Zero register wins over bypass so a discarded write never shows up.
      if (is_zero_reg(32'(rdAddr), ZERO_REG)) begin
         rdData = '0;
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file: storage, two write ports with
// port-1 priority, written-since-reset scoreboard and conflict flag.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int ADDR_W   = $clog2(NUM_REGS),
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = NUM_REGS - 1,
   parameter int BYPASS   = 1
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr,
   output logic [NUM_RD-1:0][DATA_W-1:0] rd_data,
   input  logic                          we0,
   input  logic [ADDR_W-1:0]             wa0,
   input  logic [DATA_W-1:0]             wd0,
   input  logic                          we1,
   input  logic [ADDR_W-1:0]             wa1,
   input  logic [DATA_W-1:0]             wd1,
   output logic [NUM_REGS-1:0]           written,
   output logic                          wr_conflict
);

   logic [NUM_REGS-1:0][DATA_W-1:0] regs;
   logic                            wrOk0;
   logic                            wrOk1;
   logic                            byp0;
   logic                            byp1;

   assign wrOk0 = we0 && !is_zero_reg(32'(wa0), ZERO_REG);
   assign wrOk1 = we1 && !is_zero_reg(32'(wa1), ZERO_REG);

   // A write held during reset never commits, so it must not be forwarded either.
   assign byp0 = we0 && reset_n;
   assign byp1 = we1 && reset_n;

   // Port 1 is issued last so its non-blocking update wins on a shared address.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         regs        <= '0;
         written     <= '0;
         wr_conflict <= 1'b0;
      end else begin
         wr_conflict <= we0 && we1 && (wa0 == wa1);
         if (wrOk0) begin
            regs[wa0]    <= wd0;
            written[wa0] <= 1'b1;
         end
         if (wrOk1) begin
            regs[wa1]    <= wd1;
            written[wa1] <= 1'b1;
         end
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : gRd
      regfile_rdport #(
         .DATA_W   (DATA_W),
         .NUM_REGS (NUM_REGS),
         .ADDR_W   (ADDR_W),
         .ZERO_REG (ZERO_REG),
         .BYPASS   (BYPASS)
      ) uRdPort (
         .rdAddr (rd_addr[k]),
         .regs   (regs),
         .we0    (byp0),
         .wa0    (wa0),
         .wd0    (wd0),
         .we1    (byp1),
         .wa1    (wa1),
         .wd1    (wd1),
         .rdData (rd_data[k])
      );
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: bypass and non-bypass instances share
// stimulus and are compared against an array-based reference model.
module tb_regfile_mp;

   localparam int          NR  = 32;
   localparam int          DW  = 64;
   localparam int          NRD = 2;
   localparam logic [4:0]  ZRA = 5'd31;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                     reset_n;
   logic [NRD-1:0][4:0]      rd_addr;
   logic [NRD-1:0][DW-1:0]   rdB, rdN;
   logic                     we0, we1;
   logic [4:0]               wa0, wa1;
   logic [DW-1:0]            wd0, wd1;
   logic [NR-1:0]            wrB, wrN;
   logic                     cfB, cfN;

   regfile_mp #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD), .ZERO_REG(31), .BYPASS(1)) dut (
      .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rdB),
      .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
      .written(wrB), .wr_conflict(cfB));

   regfile_mp #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD), .ZERO_REG(31), .BYPASS(0)) dutNb (
      .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rdN),
      .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
      .written(wrN), .wr_conflict(cfN));

   // Reference model
   logic [DW-1:0] mReg [NR];
   logic [NR-1:0] mWritten;
   logic          mConf;
   int            nChecks = 0;
   int            nPass   = 0;

   task automatic model_reset();
      for (int i = 0; i < NR; i++) mReg[i] = '0;
      mWritten = '0;
      mConf    = 1'b0;
   endtask

   function automatic logic [DW-1:0] exp_rd(input logic [4:0] addr, input bit byp);
      if (addr == ZRA) return '0;
      if (byp && reset_n) begin
         if (we1 && wa1 == addr) return wd1;
         if (we0 && wa0 == addr) return wd0;
      end
      return mReg[addr];
   endfunction

   task automatic tick();
      if (reset_n) begin
         mConf = we0 && we1 && (wa0 == wa1);
         if (we0 && wa0 != ZRA) begin mReg[wa0] = wd0; mWritten[wa0] = 1'b1; end
         if (we1 && wa1 != ZRA) begin mReg[wa1] = wd1; mWritten[wa1] = 1'b1; end
      end else begin
         model_reset();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      we0 = 0; we1 = 0; wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      idle_inputs();
      rd_addr = '0;
      model_reset();
      #12;
      for (int a = 0; a < NR; a++) begin
         rd_addr = {NRD{5'(a)}};
         #1;
         for (int k = 0; k < NRD; k++) begin
            nChecks++;
            if (rdB[k] !== '0 || rdN[k] !== '0)
               $display("FAIL reset_rd a%0d p%0d: got %h/%h want 0", a, k, rdB[k], rdN[k]);
            else nPass++;
         end
      end
      nChecks++;
      if (wrB !== '0 || cfB !== 1'b0) $display("FAIL reset_flags: got %h/%b want 0/0", wrB, cfB);
      else nPass++;
      @(posedge clk); #1;
      reset_n = 1'b1;
      // Write reg3, then pulse reset mid-cycle while a second write is pending.
      we0 = 1; wa0 = 3; wd0 = 64'h1234;
      tick();
      wd0 = 64'hFF;
      rd_addr = {5'd3, 5'd3};
      #1;
      nChecks++;
      if (rdN[0] !== 64'h1234 || rdB[0] !== 64'hFF)
         $display("FAIL pre_reset_rd3: got %h/%h want 1234/ff", rdN[0], rdB[0]);
      else nPass++;
      #1 reset_n = 1'b0;
      model_reset();
      #1;
      nChecks++;
      if (rdB[0] !== '0 || rdN[1] !== '0 || wrB !== '0 || cfB !== 1'b0)
         $display("FAIL async_reset: got rd %h/%h wr %h cf %b want 0", rdB[0], rdN[1], wrB, cfB);
      else nPass++;
      tick();
      nChecks++;
      if (rdN[0] !== '0 || wrN !== '0)
         $display("FAIL reset_hold_write: got rd %h wr %h want 0/0", rdN[0], wrN);
      else nPass++;
      reset_n = 1'b1;
      tick();
      nChecks++;
      if (rdN[0] !== 64'hFF || wrN !== 32'h8) $display("FAIL first_after_release: got %h wr %h want ff/8", rdN[0], wrN);
      else nPass++;
      idle_inputs();
   endtask

   task automatic test_zero_reg();
      we0 = 1; wa0 = ZRA; wd0 = 64'hA0;
      rd_addr = {5'd31, 5'd31};
      #1;
      nChecks++;
      if (rdB[0] !== '0 || rdN[0] !== '0 || wrB[31] !== 1'b0)
         $display("FAIL zero_during: got %h/%h w31 %b want 0/0/0", rdB[0], rdN[0], wrB[31]);
      else nPass++;
      tick();
      nChecks++;
      if (rdB[0] !== '0 || rdN[0] !== '0 || wrB[31] !== 1'b0 || wrN[31] !== 1'b0)
         $display("FAIL zero_after: got %h/%h w31 %b want 0/0/0", rdB[0], rdN[0], wrB[31]);
      else nPass++;
      idle_inputs();
   endtask

   task automatic test_pattern_fill();
      logic [DW-1:0] pat;
      pat = 64'h0000010204080001;
      for (int i = 0; i < NR - 1; i++) begin
         idle_inputs();
         if (i % 2 == 0) begin we0 = 1; wa0 = 5'(i); wd0 = pat * DW'(i); end
         else            begin we1 = 1; wa1 = 5'(i); wd1 = pat * DW'(i); end
         tick();
      end
      idle_inputs();
      for (int i = 0; i < NR; i++) begin
         rd_addr = {NRD{5'(i)}};
         #1;
         for (int k = 0; k < NRD; k++) begin
            nChecks++;
            if (rdB[k] !== exp_rd(5'(i), 1) || rdN[k] !== exp_rd(5'(i), 0) ||
                (i < NR - 1 && rdN[k] !== pat * DW'(i)))
               $display("FAIL fill r%0d p%0d: got %h/%h want %h", i, k, rdB[k], rdN[k], exp_rd(5'(i), 0));
            else nPass++;
         end
      end
      nChecks++;
      if (wrB !== 32'h7FFFFFFF || wrN !== 32'h7FFFFFFF)
         $display("FAIL fill_written: got %h want 7fffffff", wrB);
      else nPass++;
   endtask

   task automatic test_conflict();
      we0 = 1; we1 = 1; wa0 = 5; wa1 = 5; wd0 = 64'h11; wd1 = 64'h22;
      tick();
      idle_inputs();
      rd_addr = {5'd5, 5'd5};
      #1;
      nChecks++;
      if (rdN[0] !== 64'h22 || cfB !== 1'b1 || cfN !== mConf)
         $display("FAIL conflict: got reg5 %h cf %b want 22/1", rdN[0], cfB);
      else nPass++;
      tick();
      nChecks++;
      if (cfB !== 1'b0 || cfB !== mConf) $display("FAIL conflict_one_cycle: got %b want 0", cfB);
      else nPass++;
   endtask

   task automatic test_dual_write();
      we0 = 1; wa0 = 7; wd0 = 64'h77; we1 = 1; wa1 = 8; wd1 = 64'h88;
      tick();
      idle_inputs();
      rd_addr = {5'd8, 5'd7};
      #1;
      nChecks++;
      if (rdN[0] !== 64'h77 || rdN[1] !== 64'h88 || cfB !== 1'b0)
         $display("FAIL dual_write: got %h/%h cf %b want 77/88/0", rdN[0], rdN[1], cfB);
      else nPass++;
   endtask

   task automatic test_bypass();
      we0 = 1; wa0 = 9; wd0 = 64'h5;
      tick();
      wd0 = 64'h99;
      rd_addr = {5'd9, 5'd0};
      #1;
      nChecks++;
      if (rdB[1] !== 64'h99 || rdN[1] !== 64'h5)
         $display("FAIL bypass_pre_edge: got byp %h nobyp %h want 99/5", rdB[1], rdN[1]);
      else nPass++;
      tick();
      idle_inputs();
      #1;
      nChecks++;
      if (rdB[1] !== 64'h99 || rdN[1] !== 64'h99)
         $display("FAIL bypass_post_edge: got %h/%h want 99/99", rdB[1], rdN[1]);
      else nPass++;
      // Port 1 bypass takes priority over port 0.
      we0 = 1; wa0 = 12; wd0 = 64'hAA; we1 = 1; wa1 = 12; wd1 = 64'hBB;
      rd_addr = {5'd12, 5'd12};
      #1;
      nChecks++;
      if (rdB[0] !== 64'hBB || rdN[0] !== exp_rd(5'd12, 0))
         $display("FAIL bypass_priority: got %h/%h want bb/%h", rdB[0], rdN[0], exp_rd(5'd12, 0));
      else nPass++;
      tick();
      idle_inputs();
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         we0 = 1'($urandom_range(0, 1));
         we1 = 1'($urandom_range(0, 1));
         wa0 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
         wa1 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
         wd0 = {$urandom, $urandom};
         wd1 = {$urandom, $urandom};
         for (int k = 0; k < NRD; k++)
            rd_addr[k] = ($urandom_range(0, 1) == 0) ? (k == 0 ? wa0 : wa1) : 5'($urandom_range(0, 31));
         #1;
         for (int k = 0; k < NRD; k++) begin
            nChecks++;
            if (rdB[k] !== exp_rd(rd_addr[k], 1) || rdN[k] !== exp_rd(rd_addr[k], 0))
               $display("FAIL rand_rd n%0d p%0d a%0d: got %h/%h want %h/%h", n, k, rd_addr[k],
                        rdB[k], rdN[k], exp_rd(rd_addr[k], 1), exp_rd(rd_addr[k], 0));
            else nPass++;
         end
         tick();
         nChecks++;
         if (wrB !== mWritten || wrN !== mWritten || cfB !== mConf || cfN !== mConf)
            $display("FAIL rand_flags n%0d: got wr %h cf %b want %h/%b", n, wrB, cfB, mWritten, mConf);
         else nPass++;
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_zero_reg();
      test_pattern_fill();
      test_conflict();
      test_dual_write();
      test_bypass();
      test_random();
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
